// File: rtl/mem_access_stage.sv
// MEM stage: data-memory load/store over req/ack with timeout, feeds MEM/WB.
// Define ALIGN_CHECK_EN to reject misaligned accesses instead of word-aligning.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WrData_i,
  input  logic [4:0]  RegAddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] MemData_o,
  output logic [31:0] ALUData_o,
  output logic [4:0]  RegAddr_o,
  output logic        err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [31:0] buf_q, buf_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] memdata_q, memdata_d;
  logic [31:0] aludata_q, aludata_d;
  logic [4:0]  regaddr_q, regaddr_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
  logic        stall;
  logic        access;
  logic        misal;

  assign access = MemRead_i | MemWrite_i;

`ifdef ALIGN_CHECK_EN
  assign misal = (Addr_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    buf_d     = buf_q;
    wb_d      = wb_q;
    memdata_d = memdata_q;
    aludata_d = aludata_q;
    regaddr_d = regaddr_q;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && !misal) begin
          stall   = 1'b1;
          addr_d  = {Addr_i[31:2], 2'b00};
          wdata_d = WrData_i;
          we_d    = MemWrite_i;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          abort_d = 1'b0;
          buf_d   = 32'd0;
          wb_d    = 2'b00;
          state_d = REQ;
        end else if (access) begin
          wb_d  = 2'b00;
          mis_d = 1'b1;
        end else begin
          wb_d      = WB_i;
          aludata_d = Addr_i;
          regaddr_d = RegAddr_i;
          memdata_d = 32'd0;
        end
      end
      REQ: begin
        stall = 1'b1;
        wb_d  = 2'b00;
        // ack has priority over a timeout landing in the same cycle
        if (mem_ack_i) begin
          if (!we_q) buf_d = mem_rdata_i;
          req_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          req_d   = 1'b0;
          abort_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        wb_d      = abort_q ? 2'b00 : WB_i;
        aludata_d = Addr_i;
        regaddr_d = RegAddr_i;
        memdata_d = buf_q;
        err_d     = abort_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= 8'd0;
      abort_q   <= 1'b0;
      buf_q     <= 32'd0;
      wb_q      <= 2'b00;
      memdata_q <= 32'd0;
      aludata_q <= 32'd0;
      regaddr_q <= 5'd0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      buf_q     <= buf_d;
      wb_q      <= wb_d;
      memdata_q <= memdata_d;
      aludata_q <= aludata_d;
      regaddr_q <= regaddr_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign stall_o     = stall & ~rst_i;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign WB_o        = wb_q;
  assign MemData_o   = memdata_q;
  assign ALUData_o   = aludata_q;
  assign RegAddr_o   = regaddr_q;
  assign err_o       = err_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected MEM/WB
// entries, a negedge monitor pops and compares each retired entry.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  WB_i = 2'b00;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [31:0] Addr_i = 32'd0;
  logic [31:0] WrData_i = 32'd0;
  logic [4:0]  RegAddr_i = 5'd0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] MemData_o;
  logic [31:0] ALUData_o;
  logic [4:0]  RegAddr_o;
  logic        err_o;
  logic        misalign_o;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .WB_i(WB_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .Addr_i(Addr_i), .WrData_i(WrData_i), .RegAddr_i(RegAddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .WB_o(WB_o), .MemData_o(MemData_o),
    .ALUData_o(ALUData_o), .RegAddr_o(RegAddr_o),
    .err_o(err_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  ra;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int          ack_at = 0;
  logic [31:0] rd_val = 32'd0;
  int          req_cnt = 0;
  int          last_len = 0;
  int          req_total = 0;
  logic [31:0] cap_addr = 32'd0;
  logic [31:0] cap_wdata = 32'd0;
  logic        cap_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] wb, input logic [31:0] md,
                      input logic [31:0] alu, input logic [4:0] ra,
                      input logic err, input logic mis);
    exp_t e;
    e.wb = wb; e.md = md; e.alu = alu;
    e.ra = ra; e.err = err; e.mis = mis;
    sbq.push_back(e);
  endtask

  // Memory responder: acks in REQ cycle number ack_at (0 = never)
  always @(negedge clk) begin
    if (mem_req_o) begin
      req_cnt++;
      req_total++;
      if (req_cnt == 1) begin
        cap_addr  = mem_addr_o;
        cap_wdata = mem_wdata_o;
        cap_we    = mem_we_o;
      end
      last_len    = req_cnt;
      mem_ack_i   = (ack_at != 0) && (req_cnt == ack_at);
      mem_rdata_i = mem_ack_i ? rd_val : 32'd0;
    end else begin
      req_cnt     = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'd0;
    end
  end

  // Monitor: any non-bubble MEM/WB entry must match the scoreboard head
  always @(negedge clk) begin
    if (!rst_i && (WB_o != 2'b00 || err_o || misalign_o)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: got wb=%b err=%b mis=%b required none",
                 WB_o, err_o, misalign_o);
      end else begin
        mon_e = sbq.pop_front();
        chk("ret_wb", {30'd0, WB_o}, {30'd0, mon_e.wb});
        chk("ret_err", {31'd0, err_o}, {31'd0, mon_e.err});
        chk("ret_mis", {31'd0, misalign_o}, {31'd0, mon_e.mis});
        if (!mon_e.err && !mon_e.mis) begin
          chk("ret_memdata", MemData_o, mon_e.md);
          chk("ret_aludata", ALUData_o, mon_e.alu);
          chk("ret_regaddr", {27'd0, RegAddr_o}, {27'd0, mon_e.ra});
        end
      end
    end
  end

  task automatic nop();
    WB_i = 2'b00; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    Addr_i = 32'd0; WrData_i = 32'd0; RegAddr_i = 5'd0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] wb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] ra, input int ack_n,
                       input logic [31:0] rdv, output int nst);
    bit done;
    ack_at = ack_n; rd_val = rdv;
    WB_i = wb; MemRead_i = rd; MemWrite_i = wr;
    Addr_i = addr; WrData_i = wdata; RegAddr_i = ra;
    nst = 0;
    done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
        break;
      end
      nst++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stall_release: got stall held 64 cycles required release");
    end
    @(posedge clk);
    #1;
    nop();
  endtask

  int n;
  int rt0;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    #1 rst_i = 1'b1;
    #2;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb", {30'd0, WB_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_memdata", MemData_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    push(2'b01, 32'd0, 32'h1234, 5'd5, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 2'b01, 32'h1234, 32'd0, 5'd5, 0, 32'd0, n);
    chk("alu_stall", n, 0);

    push(2'b11, 32'hDEADBEEF, 32'h40, 5'd7, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 32'h40, 32'd0, 5'd7, 3, 32'hDEADBEEF, n);
    chk("load_stall", n, 4);
    chk("load_addr", cap_addr, 32'h40);
    chk("load_we", {31'd0, cap_we}, 32'd0);
    chk("load_len", last_len, 3);

    push(2'b01, 32'd0, 32'h80, 5'd3, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd3, 1, 32'h12345678, n);
    chk("store_stall", n, 2);
    chk("store_addr", cap_addr, 32'h80);
    chk("store_we", {31'd0, cap_we}, 32'd1);
    chk("store_wdata", cap_wdata, 32'hA5A5A5A5);

    push(2'b00, 32'd0, 32'h100, 5'd9, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 32'h100, 32'd0, 5'd9, 0, 32'd0, n);
    chk("tmo_stall", n, 5);
    chk("tmo_len", last_len, 4);
    repeat (3) @(posedge clk);
    #1;

    push(2'b10, 32'hCAFEF00D, 32'h104, 5'd10, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 2'b10, 32'h104, 32'd0, 5'd10, 4, 32'hCAFEF00D, n);
    chk("lateack_stall", n, 5);
    chk("lateack_len", last_len, 4);

    rt0 = req_total;
`ifdef ALIGN_CHECK_EN
    push(2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b11, 32'h42, 32'd0, 5'd11, 1, 32'h11112222, n);
    chk("mis_stall", n, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mis_noreq", req_total, rt0);
`else
    push(2'b11, 32'h11112222, 32'h42, 5'd11, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 2'b11, 32'h42, 32'd0, 5'd11, 1, 32'h11112222, n);
    chk("mis_stall", n, 2);
    chk("mis_addr", cap_addr, 32'h40);
    chk("mis_reqs", req_total - rt0, 1);
`endif

    ack_at = 0;
    WB_i = 2'b11; MemRead_i = 1'b1; Addr_i = 32'h200; RegAddr_i = 5'd12;
    repeat (3) @(negedge clk);
    chk("midreq_req", {31'd0, mem_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("midreq_rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("midreq_rst_wb", {30'd0, WB_o}, 32'd0);
    chk("midreq_rst_err", {31'd0, err_o}, 32'd0);
    nop();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;

    push(2'b01, 32'd0, 32'h55AA, 5'd31, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 2'b01, 32'h55AA, 32'd0, 5'd31, 0, 32'd0, n);
    chk("post_rst_stall", n, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
